// File: rtl/lcd_frame_ctrl.sv
// HD44780 2x16 character LCD controller: power-up wait and init commands, then full-screen
// redraws from a captured 256-bit message on refresh requests.
//
// state  | meaning
// PWR    | post-reset power-up wait before the first command
// INIT   | writing the function-set / display-on / clear / entry-mode commands
// IDLE   | waiting for refresh_i
// FRAME  | writing the 34 bytes of one screen (two address commands + 32 characters)
//
// write  | meaning
// W_SETUP| rs/data presented, enable low for one cycle
// W_EN   | enable high for EN_CYCLES
// W_WAIT | enable low for the command's execution time
module lcd_frame_ctrl #(
    parameter int INIT_WAIT = 750000,
    parameter int EN_CYCLES = 12,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [255:0] msg_i,
    input  logic         refresh_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         lcd_on_o,
    output logic         lcd_blon_o,
    output logic         lcd_rw_o,
    output logic         lcd_en_o,
    output logic         lcd_rs_o,
    output logic [7:0]   lcd_data_o
);

    typedef enum logic [1:0] {PWR, INIT, IDLE, FRAME} top_t;
    typedef enum logic [1:0] {W_SETUP, W_EN, W_WAIT} wr_t;

    // A zero parameter would make a zero-length phase; clamp to one cycle.
    localparam int INIT_E = (INIT_WAIT < 1) ? 1 : INIT_WAIT;
    localparam int EN_E   = (EN_CYCLES < 1) ? 1 : EN_CYCLES;
    localparam int CMD_E  = (CMD_WAIT  < 1) ? 1 : CMD_WAIT;
    localparam int CLR_E  = (CLR_WAIT  < 1) ? 1 : CLR_WAIT;
    localparam int MAX_A  = (INIT_E > CLR_E) ? INIT_E : CLR_E;
    localparam int MAX_B  = (CMD_E > EN_E) ? CMD_E : EN_E;
    localparam int MAX_W  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW     = $clog2(MAX_W + 1);

    localparam logic [CW-1:0] INIT_LD = CW'(INIT_E - 1);
    localparam logic [CW-1:0] EN_LD   = CW'(EN_E - 1);
    localparam logic [CW-1:0] CMD_LD  = CW'(CMD_E - 1);
    localparam logic [CW-1:0] CLR_LD  = CW'(CLR_E - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    localparam logic [5:0] INIT_LAST  = 6'd3;
    localparam logic [5:0] CLR_IDX    = 6'd2;
    localparam logic [5:0] FRAME_LAST = 6'd33;

    top_t           top, top_n;
    wr_t            wst, wst_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [5:0]     idx, idx_n;
    logic           pending, pend_n;
    logic [255:0]   shadow, shadow_n;
    logic           en_n, rs_n, done_n;
    logic [7:0]     data_n;
    logic           start_wr;
    logic           last_wr;
    logic [8:0]     sel;

    // {rs, data} for write i of the given phase; character bytes come from the shadow copy.
    function automatic logic [8:0] wr_byte(input top_t t, input logic [5:0] i,
                                           input logic [255:0] sh);
        int         k;
        logic [8:0] r;
        r = 9'h000;
        k = 0;
        if (t == INIT) begin
            case (i[1:0])
                2'd0:    r = {1'b0, 8'h38};
                2'd1:    r = {1'b0, 8'h0C};
                2'd2:    r = {1'b0, 8'h01};
                default: r = {1'b0, 8'h06};
            endcase
        end else if (t == FRAME) begin
            if (i == 6'd0) begin
                r = {1'b0, 8'h80};
            end else if (i == 6'd17) begin
                r = {1'b0, 8'hC0};
            end else begin
                k = (i < 6'd17) ? int'(i) - 1 : int'(i) - 2;
                r = {1'b1, sh[8*(31-k) +: 8]};
            end
        end
        return r;
    endfunction

    always_comb begin
        top_n    = top;
        wst_n    = wst;
        cnt_n    = cnt;
        idx_n    = idx;
        pend_n   = pending;
        shadow_n = shadow;
        en_n     = lcd_en_o;
        rs_n     = lcd_rs_o;
        data_n   = lcd_data_o;
        done_n   = 1'b0;
        start_wr = 1'b0;
        sel      = 9'h000;
        last_wr  = ((top == INIT) && (idx == INIT_LAST)) ||
                   ((top == FRAME) && (idx == FRAME_LAST));

        if (refresh_i && (top != IDLE)) begin
            pend_n = 1'b1;
        end

        case (top)
            PWR: begin
                if (cnt == '0) begin
                    top_n    = INIT;
                    idx_n    = '0;
                    start_wr = 1'b1;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            IDLE: begin
                if (refresh_i) begin
                    shadow_n = msg_i;
                    top_n    = FRAME;
                    idx_n    = '0;
                    start_wr = 1'b1;
                end
            end
            default: begin
                case (wst)
                    W_SETUP: begin
                        wst_n = W_EN;
                        en_n  = 1'b1;
                        cnt_n = EN_LD;
                    end
                    W_EN: begin
                        if (cnt == '0) begin
                            wst_n = W_WAIT;
                            en_n  = 1'b0;
                            cnt_n = ((top == INIT) && (idx == CLR_IDX)) ? CLR_LD : CMD_LD;
                        end else begin
                            cnt_n = cnt - ONE;
                        end
                    end
                    default: begin
                        if (cnt != '0) begin
                            cnt_n = cnt - ONE;
                        end else if (!last_wr) begin
                            idx_n    = idx + 6'd1;
                            start_wr = 1'b1;
                        end else begin
                            done_n = (top == FRAME);
                            // A request seen during the run (or on this very edge) chains
                            // straight into a new frame without visiting IDLE.
                            if (pending || refresh_i) begin
                                pend_n   = 1'b0;
                                shadow_n = msg_i;
                                top_n    = FRAME;
                                idx_n    = '0;
                                start_wr = 1'b1;
                            end else begin
                                top_n = IDLE;
                            end
                        end
                    end
                endcase
            end
        endcase

        if (start_wr) begin
            sel    = wr_byte(top_n, idx_n, shadow);
            wst_n  = W_SETUP;
            rs_n   = sel[8];
            data_n = sel[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            top        <= PWR;
            wst        <= W_SETUP;
            cnt        <= INIT_LD;
            idx        <= '0;
            pending    <= 1'b0;
            shadow     <= '0;
            lcd_en_o   <= 1'b0;
            lcd_rs_o   <= 1'b0;
            lcd_data_o <= 8'h00;
            done_o     <= 1'b0;
        end else begin
            top        <= top_n;
            wst        <= wst_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            pending    <= pend_n;
            shadow     <= shadow_n;
            lcd_en_o   <= en_n;
            lcd_rs_o   <= rs_n;
            lcd_data_o <= data_n;
            done_o     <= done_n;
        end
    end

    assign busy_o     = (top != IDLE);
    assign lcd_on_o   = 1'b1;
    assign lcd_blon_o = 1'b1;
    assign lcd_rw_o   = 1'b0;

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Self-checking bench for lcd_frame_ctrl: init sequence, frame contents and timing,
// request coalescing, reset mid-write and refresh held through init.
module tb_lcd_frame_ctrl;

    localparam int INIT_WAIT = 20;
    localparam int EN_CYCLES = 2;
    localparam int CMD_WAIT  = 4;
    localparam int CLR_WAIT  = 10;
    localparam int WR_CYC    = 7;
    localparam int FRAME_CYC = 238;

    localparam string S1 = "PC:-----00000004INST:---00A00093";
    localparam string S2 = "HELLO, WORLD!!!!frame two 0123ab";
    localparam string S3 = "Line one: pend 1Line two: pend 2";

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] msg = '0;
    logic         refresh = 1'b0;
    logic         busy, done, on, blon, rw, en, rs;
    logic [7:0]   data;

    lcd_frame_ctrl #(
        .INIT_WAIT(INIT_WAIT),
        .EN_CYCLES(EN_CYCLES),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .msg_i     (msg),
        .refresh_i (refresh),
        .busy_o    (busy),
        .done_o    (done),
        .lcd_on_o  (on),
        .lcd_blon_o(blon),
        .lcd_rw_o  (rw),
        .lcd_en_o  (en),
        .lcd_rs_o  (rs),
        .lcd_data_o(data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] wr;
        int         gap;
    } vec_t;

    vec_t init_tbl[4];
    vec_t frame_tbl[34];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         rise_cyc[$];
    logic [8:0] rise_wr[$];
    int         done_cyc[$];
    int         fall_cyc[$];
    logic       en_prev = 1'b0;
    logic       busy_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (en && !en_prev) begin
            rise_cyc.push_back(cyc);
            rise_wr.push_back({rs, data});
        end
        if (done) done_cyc.push_back(cyc);
        if (!busy && busy_prev) fall_cyc.push_back(cyc);
        en_prev   = en;
        busy_prev = busy;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] to_vec(input string s);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < 32; j++) v[255-8*j -: 8] = s[j];
        return v;
    endfunction

    task automatic fill_frame(input string s);
        for (int k = 0; k < 34; k++) begin
            if (k == 0)       frame_tbl[k].wr = {1'b0, 8'h80};
            else if (k == 17) frame_tbl[k].wr = {1'b0, 8'hC0};
            else if (k < 17)  frame_tbl[k].wr = {1'b1, s[k-1]};
            else              frame_tbl[k].wr = {1'b1, s[k-2]};
            frame_tbl[k].gap = (k == 0) ? 1 : WR_CYC;
        end
    endtask

    task automatic wait_for(input int rises, input int dones, input int budget, output bit ok);
        int n;
        n = 0;
        while ((rise_cyc.size() < rises || done_cyc.size() < dones) && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (rise_cyc.size() >= rises) && (done_cyc.size() >= dones);
        chk("wait_budget", {63'd0, ok}, 64'd1);
    endtask

    task automatic check_frame(input int rb, input int cap, input string s, input string tag);
        int prev;
        fill_frame(s);
        prev = cap;
        for (int k = 0; k < 34; k++) begin
            chk({tag, "_byte"}, 64'(rise_wr[rb+k]), 64'(frame_tbl[k].wr));
            chk({tag, "_gap"}, 64'(rise_cyc[rb+k] - prev), 64'(frame_tbl[k].gap));
            prev = rise_cyc[rb+k];
        end
    endtask

    task automatic check_init(input int rel, input int rb, input int fb, input bit exp_fall,
                              output bit ok);
        int prev;
        int n;
        wait_for(rb + 4, 0, 200, ok);
        if (ok) begin
            prev = rel;
            for (int k = 0; k < 4; k++) begin
                chk("init_byte", 64'(rise_wr[rb+k]), 64'(init_tbl[k].wr));
                chk("init_gap", 64'(rise_cyc[rb+k] - prev), 64'(init_tbl[k].gap));
                prev = rise_cyc[rb+k];
            end
            if (exp_fall) begin
                n = 0;
                while (fall_cyc.size() <= fb && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                // Busy drops when the 0x06 write (setup cycle one before its en rise) ends.
                chk("init_busy_fall",
                    (fall_cyc.size() > fb) ? 64'(fall_cyc[fb] - (rise_cyc[rb+3] - 1)) : 64'hFFFF,
                    64'(WR_CYC));
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rel, rb, db, fb, cap, r, n;
        bit ok;

        init_tbl[0] = '{{1'b0, 8'h38}, 21};
        init_tbl[1] = '{{1'b0, 8'h0C}, 7};
        init_tbl[2] = '{{1'b0, 8'h01}, 7};
        init_tbl[3] = '{{1'b0, 8'h06}, 13};

        repeat (3) @(negedge clk);
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_rs", 64'(rs), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("tie_on", 64'(on), 64'd1);
        chk("tie_blon", 64'(blon), 64'd1);
        chk("tie_rw", 64'(rw), 64'd0);

        rst = 1'b0;
        rel = cyc;
        rb  = rise_cyc.size();
        fb  = fall_cyc.size();
        check_init(rel, rb, fb, 1'b1, ok);

        // Frame from IDLE; message changes right after capture.
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        msg = to_vec(S1);
        refresh = 1'b1;
        rb = rise_cyc.size();
        db = done_cyc.size();
        fb = fall_cyc.size();
        @(negedge clk);
        refresh = 1'b0;
        cap = cyc;
        msg = {32{8'h41}};
        wait_for(rb + 34, db + 1, FRAME_CYC + 20, ok);
        if (ok) begin
            check_frame(rb, cap, S1, "f1");
            chk("f1_done_cyc", 64'(done_cyc[db] - cap), 64'(FRAME_CYC));
        end
        repeat (10) @(negedge clk);
        chk("f1_done_count", 64'(done_cyc.size() - db), 64'd1);
        chk("f1_idle_cyc", (fall_cyc.size() == fb + 1) ? 64'(fall_cyc[fb] - cap) : 64'hFFFF,
            64'(FRAME_CYC));

        // Three requests during a frame coalesce into exactly one chained frame.
        @(negedge clk);
        msg = to_vec(S2);
        refresh = 1'b1;
        rb = rise_cyc.size();
        db = done_cyc.size();
        fb = fall_cyc.size();
        @(negedge clk);
        refresh = 1'b0;
        cap = cyc;
        for (int p = 0; p < 3; p++) begin
            repeat (30) @(negedge clk);
            refresh = 1'b1;
            @(negedge clk);
            refresh = 1'b0;
        end
        repeat (20) @(negedge clk);
        msg = to_vec(S3);
        wait_for(rb + 68, db + 2, 2 * FRAME_CYC + 20, ok);
        if (ok) begin
            check_frame(rb, cap, S2, "f2");
            check_frame(rb + 34, cap + FRAME_CYC, S3, "f3");
            chk("f2_done_cyc", 64'(done_cyc[db] - cap), 64'(FRAME_CYC));
            chk("f3_done_cyc", 64'(done_cyc[db+1] - cap), 64'(2 * FRAME_CYC));
        end
        repeat (20) @(negedge clk);
        chk("f3_rise_count", 64'(rise_cyc.size() - rb), 64'd68);
        chk("f3_done_count", 64'(done_cyc.size() - db), 64'd2);
        chk("f3_idle_cyc", (fall_cyc.size() == fb + 1) ? 64'(fall_cyc[fb] - cap) : 64'hFFFF,
            64'(2 * FRAME_CYC));

        // Reset while enable is high on the fifth character.
        @(negedge clk);
        msg = to_vec(S1);
        refresh = 1'b1;
        db = done_cyc.size();
        @(negedge clk);
        refresh = 1'b0;
        cap = cyc;
        repeat (5 * WR_CYC + 1) @(negedge clk);
        chk("mid_en", 64'(en), 64'd1);
        chk("mid_byte", 64'({rs, data}), 64'({1'b1, 8'h2D}));
        #1 rst = 1'b1;
        #1;
        chk("mid_en_async", 64'(en), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_data", 64'({rs, data}), 64'd0);
        rst = 1'b0;
        rel = cyc;
        rb  = rise_cyc.size();
        fb  = fall_cyc.size();
        check_init(rel, rb, fb, 1'b1, ok);
        chk("mid_no_done", 64'(done_cyc.size() - db), 64'd0);

        // Refresh held through reset and init: frame follows init with no IDLE cycle.
        @(negedge clk);
        rst = 1'b1;
        refresh = 1'b1;
        msg = to_vec(S2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        rb  = rise_cyc.size();
        db  = done_cyc.size();
        fb  = fall_cyc.size();
        check_init(rel, rb, fb, 1'b0, ok);
        r = 0;
        if (ok) begin
            r = rise_cyc[rb+3];
            n = 0;
            while (cyc < r + 6 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        refresh = 1'b0;
        if (ok) begin
            wait_for(rb + 38, db + 1, FRAME_CYC + 20, ok);
            if (ok) begin
                check_frame(rb + 4, r + 6, S2, "hold");
                chk("hold_done_cyc", 64'(done_cyc[db] - r), 64'(6 + FRAME_CYC));
            end
            repeat (20) @(negedge clk);
            chk("hold_done_count", 64'(done_cyc.size() - db), 64'd1);
            chk("hold_idle_cyc", (fall_cyc.size() == fb + 1) ? 64'(fall_cyc[fb] - r) : 64'hFFFF,
                64'(6 + FRAME_CYC));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
